// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing HI/LO for the mfhi/mflo path.
// Optional macro MDU_EARLY_EXIT_EN: multiplies stop once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               signed_op, a_sgn, b_sgn, iter_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, shifted, trial;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = ~op_q[0];
  assign a_sgn     = signed_op & a_q[WIDTH-1];
  assign b_sgn     = signed_op & b_q[WIDTH-1];
  assign a_mag     = a_sgn ? (~a_q) + WIDTH'(1) : a_q;
  assign b_mag     = b_sgn ? (~b_q) + WIDTH'(1) : b_q;

  // Multiply: add into the upper half, then shift the whole accumulator right.
  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mag_q} : '0);
  // Divide: upper half is the partial remainder, lower half the dividend/quotient.
  assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial   = shifted - {1'b0, mag_q};

`ifdef MDU_EARLY_EXIT_EN
  assign prod_raw = acc_q >> cnt_q;
`else
  assign prod_raw = acc_q;
`endif

  assign prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw) + (2*WIDTH)'(1) : prod_raw;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0]) + WIDTH'(1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH]) + WIDTH'(1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    mag_d     = mag_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    iter_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q[1] && (b_q == '0)) begin
          done_d  = 1'b1;
          dz_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          neg_a_d = a_sgn;
          neg_b_d = b_sgn;
          cnt_d   = CNT_W'(WIDTH);
          if (op_q[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            mag_d = b_mag;
          end else begin
            acc_d    = '0;
            mag_d    = a_mag;
            mplier_d = b_mag;
          end
          state_d = S_ITER;
        end
      end
      S_ITER: begin
`ifdef MDU_EARLY_EXIT_EN
        // Multiplies exit on the edge after the multiplier is exhausted; FIX realigns.
        if (!op_q[1] && (mplier_q == '0) && (cnt_q != CNT_W'(WIDTH))) begin
          state_d = S_FIX;
        end else begin
          iter_step = 1'b1;
          if (op_q[1] && (cnt_q == CNT_W'(1))) state_d = S_FIX;
        end
`else
        iter_step = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (iter_step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (op_q[1]) begin
        if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d    = {add_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_q    <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_q    <= mag_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/flag/latency,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int W = 32;
`ifdef MDU_EARLY_EXIT_EN
  localparam int EARLY_LAT = 5;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_edge;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no pending operation (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        $display("txn %s: hi=0x%08h lo=0x%08h div_zero=%0b latency=%0d",
                 mon_e.name, hi, lo, div_zero, cyc - mon_e.start_edge);
        chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        chk({mon_e.name, "_div_zero"}, 64'(div_zero), 64'(mon_e.dz));
        chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.start_edge), 64'(mon_e.lat));
      end
    end
  end

  // Called at a negedge: drives start for one edge, records expectation, scrambles operands.
  task automatic launch(input string nm, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input bit expect_done);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.start_edge = cyc + 1; e.lat = elat;
    if (expect_done) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 2'b01;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk({nm, "_drained"}, 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed multiply with busy tracked through the whole operation.
    launch("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 1'b1);
    for (int i = 0; i < 34; i++) begin
      chk("mult_busy_inflight", 64'(busy), 64'd1);
      @(negedge clk);
    end
    chk("mult_done_cycle_busy", 64'(busy), 64'd0);
    drain("mult");

    // multu max*max, then a back-to-back start in the done cycle.
    launch("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", 64'(done), 64'd1);
    launch("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b1);
    chk("b2b_busy_after_done", 64'(busy), 64'd1);
    drain("b2b");

    launch("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 1'b1);
    drain("div_min");
    launch("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 1'b1);
    drain("div_7_m2");
    launch("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34, 1'b1);
    drain("mult_min");
    launch("divu_max_3", 2'b11, 32'hFFFFFFFF, 32'd3, 32'h0, 32'h55555555, 1'b0, 34, 1'b1);
    drain("divu_max");

    // Prime hi/lo = 0x11/0x22, then divide by zero must leave them untouched.
    launch("divu_prime", 2'b11, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, 1'b1);
    drain("prime");
    launch("divu_by_zero", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, 1'b1);
    drain("divzero");

    // Reset mid-iteration discards the operation.
    launch("divu_aborted", 2'b11, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 34, 1'b0);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);

    // Fresh divu with an ignored start pulse while busy.
    launch("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    drain("ignored_start");
    repeat (5) @(negedge clk);

    launch("multu_early", 2'b01, 32'h12345678, 32'd3, 32'h0, 32'h369D0368, 1'b0, EARLY_LAT, 1'b1);
    drain("early");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
